// File: rtl/dsc_pkg.sv
// Shared types and helpers for the deterministic stochastic decode path.
package dsc_pkg;

   typedef enum logic [1:0] {
      DEC_IDLE,
      DEC_ACCUM,
      DEC_HOLD
   } dec_state_t;

   // Window length is 2^W bits, where W is the width of the product being decoded.
   function automatic int win_bits(input int num_inputs, input int num_bits);
      return num_inputs * num_bits;
   endfunction

endpackage

// File: rtl/counter.sv
// Free-running wrap counter with enable; overflow pulses on the enabled cycle that wraps.
module counter #(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic overflow
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (en) begin
         count <= count + WIDTH'(1);
      end
   end

   assign overflow = en && (count == '1);

endmodule

// File: rtl/dsc_sn_decoder.sv
// Stochastic-to-binary decoder: counts ones over a 2^W-bit window and returns the count on a valid/ready port.
// Optional DSC_DEC_CYCLE_COUNT_EN adds a cycle_count port measuring the clock cost of each window.
module dsc_sn_decoder
   import dsc_pkg::*;
#(
   parameter int NUM_BITS   = 4,
   parameter int NUM_INPUTS = 2,
   localparam int W         = win_bits(NUM_INPUTS, NUM_BITS)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         sn_in,
   input  logic         sn_valid,
   output logic [W-1:0] z,
   output logic         z_valid,
   input  logic         z_ready,
   output logic         busy,
`ifdef DSC_DEC_CYCLE_COUNT_EN
   output logic [31:0]  cycle_count,
`endif
   output logic         overflow
);

   localparam logic [W:0] FULL_COUNT = (W+1)'(1) << W;

   dec_state_t state, state_nxt;
   logic       start_acc;
   logic       bit_last;
   logic [W:0] ones;
   logic [W:0] ones_final;

   assign busy       = (state == DEC_ACCUM);
   assign ones_final = ones + {{W{1'b0}}, sn_in};

   // A start is only honoured in IDLE or in the HOLD cycle where the result is taken.
   always_comb begin
      state_nxt = state;
      start_acc = 1'b0;
      case (state)
         DEC_IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               state_nxt = DEC_ACCUM;
            end
         end
         DEC_ACCUM: begin
            if (bit_last) begin
               state_nxt = DEC_HOLD;
            end
         end
         DEC_HOLD: begin
            if (z_ready) begin
               state_nxt = DEC_IDLE;
               if (start) begin
                  start_acc = 1'b1;
                  state_nxt = DEC_ACCUM;
               end
            end
         end
         default: state_nxt = DEC_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= DEC_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   counter #(
      .WIDTH(W)
   ) u_bit_cnt (
      .clk     (clk),
      .rst     (rst | start_acc),
      .en      (busy & sn_valid),
      .overflow(bit_last)
   );

   // ones is one bit wider than z so an all-ones window is detectable and saturated.
   always_ff @(posedge clk) begin
      if (rst) begin
         ones     <= '0;
         z        <= '0;
         z_valid  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (start_acc) begin
            ones <= '0;
         end else if (busy && sn_valid) begin
            ones <= ones_final;
         end

         if (bit_last) begin
            z_valid <= 1'b1;
            if (ones_final == FULL_COUNT) begin
               z        <= '1;
               overflow <= 1'b1;
            end else begin
               z        <= ones_final[W-1:0];
               overflow <= 1'b0;
            end
         end else if ((state == DEC_HOLD) && z_ready) begin
            z_valid <= 1'b0;
         end
      end
   end

`ifdef DSC_DEC_CYCLE_COUNT_EN
   // Counts every ACCUM clock, stalls included; it stops on its own once the result registers.
   always_ff @(posedge clk) begin
      if (rst || start_acc) begin
         cycle_count <= '0;
      end else if (busy) begin
         cycle_count <= cycle_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dsc_sn_decoder.sv
// Self-checking bench for dsc_sn_decoder: scoreboard of expected counts popped on each z handshake.
module tb_dsc_sn_decoder;

   localparam int W = 8;
   localparam int N = 1 << W;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sn_in;
   logic         sn_valid;
   logic         z_ready;
   logic [W-1:0] z;
   logic         z_valid;
   logic         busy;
   logic         overflow;
`ifdef DSC_DEC_CYCLE_COUNT_EN
   logic [31:0]  cycle_count;
`endif

   typedef struct packed {
      logic [W-1:0] z;
      logic         ovf;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   dsc_sn_decoder #(
      .NUM_BITS  (4),
      .NUM_INPUTS(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .sn_in      (sn_in),
      .sn_valid   (sn_valid),
      .z          (z),
      .z_valid    (z_valid),
      .z_ready    (z_ready),
      .busy       (busy),
`ifdef DSC_DEC_CYCLE_COUNT_EN
      .cycle_count(cycle_count),
`endif
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every accepted result must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && z_valid && z_ready) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_z_valid", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            checkOutput("z", 32'(z), 32'(e.z));
            checkOutput("overflow", 32'(overflow), 32'(e.ovf));
         end
      end
   end

   // Runs one window: num_ones ones first, then zeros. stall_mode 0 none, 1 alternate, 2 random.
   task automatic applyStimulus(input int num_ones, input int stall_mode, output int accum_cycles);
      int   sent;
      bit   vld;
      exp_t e;
      sent     = 0;
      start    = 1'b1;
      sn_valid = 1'b1;
      sn_in    = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("busy_after_start", 32'(busy), 32'd1);
      accum_cycles = 0;
      while (sent < N && accum_cycles < 8 * N) begin
         case (stall_mode)
            1:       vld = ((accum_cycles % 2) == 1);
            2:       vld = ($urandom_range(3) != 0);
            default: vld = 1'b1;
         endcase
         sn_valid = vld;
         sn_in    = vld ? (sent < num_ones) : 1'($urandom_range(1));
         if (vld && sent == N - 1) begin
            checkOutput("z_valid_before_last", 32'(z_valid), 32'd0);
            e.z   = (num_ones >= N) ? '1 : W'(num_ones);
            e.ovf = (num_ones >= N);
            exp_q.push_back(e);
         end
         if (vld) sent++;
         tick();
         accum_cycles++;
      end
      sn_valid = 1'b0;
      sn_in    = 1'b0;
      if (sent < N) checkOutput("window_timeout", 32'(sent), 32'(N));
      checkOutput("z_valid_latency", 32'(z_valid), 32'd1);
      checkOutput("busy_after_window", 32'(busy), 32'd0);
   endtask

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cyc;
      int a;
      int b;
      rst      = 1'b1;
      start    = 1'b0;
      sn_in    = 1'b0;
      sn_valid = 1'b0;
      z_ready  = 1'b1;
      tick();
      tick();
      checkOutput("reset_z", 32'(z), 32'd0);
      checkOutput("reset_z_valid", 32'(z_valid), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_overflow", 32'(overflow), 32'd0);
`ifdef DSC_DEC_CYCLE_COUNT_EN
      checkOutput("reset_cycle_count", cycle_count, 32'd0);
`endif
      rst = 1'b0;
      tick();

      $display("[TB] 225 ones then 31 zeros");
      applyStimulus(225, 0, cyc);
      tick();

      $display("[TB] all ones saturates");
      applyStimulus(256, 0, cyc);
      tick();
      checkOutput("z_kept_after_handshake", 32'(z), 32'd255);
      checkOutput("z_valid_dropped", 32'(z_valid), 32'd0);

      $display("[TB] alternating stalls");
      applyStimulus(6, 1, cyc);
`ifdef DSC_DEC_CYCLE_COUNT_EN
      checkOutput("cycle_count_stalled", cycle_count, 32'd512);
`endif
      tick();

      $display("[TB] hold with z_ready low, then handshake with start");
      z_ready = 1'b0;
      applyStimulus(77, 0, cyc);
      repeat (10) begin
         tick();
         checkOutput("hold_z", 32'(z), 32'd77);
         checkOutput("hold_z_valid", 32'(z_valid), 32'd1);
         checkOutput("hold_busy", 32'(busy), 32'd0);
      end
      z_ready = 1'b1;
      applyStimulus(140, 2, cyc);
`ifdef DSC_DEC_CYCLE_COUNT_EN
      checkOutput("cycle_count_random", cycle_count, 32'(cyc));
`endif
      tick();

      $display("[TB] reset mid-window");
      start    = 1'b1;
      sn_valid = 1'b1;
      sn_in    = 1'b1;
      tick();
      start = 1'b0;
      repeat (100) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("midreset_busy", 32'(busy), 32'd0);
      checkOutput("midreset_z_valid", 32'(z_valid), 32'd0);
      repeat (300) tick();
      checkOutput("midreset_no_result", 32'(z_valid), 32'd0);
      checkOutput("midreset_idle", 32'(busy), 32'd0);
      sn_valid = 1'b0;
      applyStimulus(3, 0, cyc);
      tick();

      $display("[TB] random a*b windows");
      repeat (150) begin
         a = $urandom_range(15);
         b = $urandom_range(15);
         applyStimulus(a * b, ($urandom_range(1) == 1) ? 2 : 0, cyc);
         if ($urandom_range(3) == 0) begin
            z_ready = 1'b0;
            repeat ($urandom_range(4, 1)) tick();
            z_ready = 1'b1;
         end
         tick();
      end

      tick();
      checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
